// File: rtl/id_stage_if.sv
// Signal bundle between the MIPS ID stage and its neighbours: IF/ID inputs, writeback,
// EX/MEM feedback, hazard/redirect outputs and the registered ID/EX fields.
interface id_stage_if;
  logic [31:0] if_id_pc_next;
  logic [31:0] if_id_instruction;

  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;

  logic        ex_mem_reg_write;
  logic        ex_mem_mem_read;
  logic [4:0]  ex_mem_write_reg;
  logic [31:0] ex_mem_alu_result;
  logic [4:0]  ex_write_reg;

  logic        stall;
  logic        flush_if;
  logic        jump_taken;
  logic [31:0] pc_jump;
  logic        branch_eq_taken;
  logic        branch_neq_taken;
  logic [31:0] pc_branch;

  logic        id_ex_reg_write;
  logic        id_ex_mem_to_reg;
  logic        id_ex_mem_read;
  logic        id_ex_mem_write;
  logic        id_ex_alu_src;
  logic        id_ex_reg_dst;
  logic [3:0]  id_ex_alu_op;
  logic [31:0] id_ex_rs_data;
  logic [31:0] id_ex_rt_data;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;
  logic [4:0]  id_ex_shamt;

  // The pipeline environment (fetch/EX/MEM/WB) is the master; the ID stage is the slave.
  modport master (
    output if_id_pc_next, if_id_instruction,
    output wb_reg_write, wb_write_reg, wb_write_data,
    output ex_mem_reg_write, ex_mem_mem_read, ex_mem_write_reg, ex_mem_alu_result, ex_write_reg,
    input  stall, flush_if, jump_taken, pc_jump, branch_eq_taken, branch_neq_taken, pc_branch,
    input  id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src,
    input  id_ex_reg_dst, id_ex_alu_op, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
    input  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt
  );

  modport slave (
    input  if_id_pc_next, if_id_instruction,
    input  wb_reg_write, wb_write_reg, wb_write_data,
    input  ex_mem_reg_write, ex_mem_mem_read, ex_mem_write_reg, ex_mem_alu_result, ex_write_reg,
    output stall, flush_if, jump_taken, pc_jump, branch_eq_taken, branch_neq_taken, pc_branch,
    output id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src,
    output id_ex_reg_dst, id_ex_alu_op, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
    output id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt
  );
endinterface

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: register file, control decode, branch/jump resolution,
// hazard stalls and ID/EX register. Define ID_BRANCH_FWD_EN to forward EX/MEM ALU results to the branch comparator.
module id_stage (
  input logic   clk,
  input logic   rst,
  id_stage_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic [3:0]  alu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
  } id_ex_t;

  logic [31:0][31:0] regs_q, regs_d;
  id_ex_t            id_ex_q, id_ex_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [31:0] imm_ext;
  logic [31:0] rs_data, rt_data;
  logic [31:0] cmp_rs, cmp_rt;

  logic    dec_reg_write, dec_mem_to_reg, dec_mem_read, dec_mem_write, dec_alu_src, dec_reg_dst;
  alu_op_e dec_alu_op;
  logic    zero_ext, reads_rt, is_beq, is_bne, is_j;
  logic    load_use, br_dep_rs, br_dep_rt, stall, operands_equal;

  assign opcode = bus.if_id_instruction[31:26];
  assign rs     = bus.if_id_instruction[25:21];
  assign rt     = bus.if_id_instruction[20:16];
  assign rd     = bus.if_id_instruction[15:11];
  assign shamt  = bus.if_id_instruction[10:6];
  assign funct  = bus.if_id_instruction[5:0];
  assign imm16  = bus.if_id_instruction[15:0];

  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_alu_src    = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_alu_op     = ALU_ADD;
    zero_ext       = 1'b0;
    reads_rt       = 1'b0;
    is_beq         = 1'b0;
    is_bne         = 1'b0;
    is_j           = 1'b0;
    case (opcode)
      6'h00: begin
        reads_rt      = 1'b1;
        dec_reg_write = 1'b1;
        dec_reg_dst   = 1'b1;
        case (funct)
          6'h20, 6'h21: dec_alu_op = ALU_ADD;
          6'h22, 6'h23: dec_alu_op = ALU_SUB;
          6'h24:        dec_alu_op = ALU_AND;
          6'h25:        dec_alu_op = ALU_OR;
          6'h26:        dec_alu_op = ALU_XOR;
          6'h27:        dec_alu_op = ALU_NOR;
          6'h2a:        dec_alu_op = ALU_SLT;
          6'h00:        dec_alu_op = ALU_SLL;
          6'h02:        dec_alu_op = ALU_SRL;
          6'h03:        dec_alu_op = ALU_SRA;
          default: begin
            dec_reg_write = 1'b0;
            dec_reg_dst   = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09: begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; end
      6'h0c: begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_AND; zero_ext = 1'b1; end
      6'h0d: begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_OR;  zero_ext = 1'b1; end
      6'h0e: begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_XOR; zero_ext = 1'b1; end
      6'h0a: begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_SLT; end
      6'h0f: begin dec_reg_write = 1'b1; dec_alu_src = 1'b1; dec_alu_op = ALU_LUI; end
      6'h23: begin
        dec_reg_write  = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_mem_read   = 1'b1;
        dec_alu_src    = 1'b1;
      end
      6'h2b: begin dec_mem_write = 1'b1; dec_alu_src = 1'b1; reads_rt = 1'b1; end
      6'h04: begin is_beq = 1'b1; reads_rt = 1'b1; end
      6'h05: begin is_bne = 1'b1; reads_rt = 1'b1; end
      6'h02: is_j = 1'b1;
      default: ;
    endcase
  end

  assign imm_ext = zero_ext ? {16'b0, imm16} : {{16{imm16[15]}}, imm16};

  // Register reads see a same-cycle writeback so WB -> ID needs no extra stall.
  assign rs_data = (rs == 5'd0) ? 32'd0 :
                   (bus.wb_reg_write && bus.wb_write_reg == rs) ? bus.wb_write_data : regs_q[rs];
  assign rt_data = (rt == 5'd0) ? 32'd0 :
                   (bus.wb_reg_write && bus.wb_write_reg == rt) ? bus.wb_write_data : regs_q[rt];

  always_comb begin
    regs_d = regs_q;
    if (bus.wb_reg_write && bus.wb_write_reg != 5'd0)
      regs_d[bus.wb_write_reg] = bus.wb_write_data;
  end

  assign load_use = id_ex_q.mem_read && (id_ex_q.rt != 5'd0) &&
                    ((id_ex_q.rt == rs) || (reads_rt && id_ex_q.rt == rt));

`ifdef ID_BRANCH_FWD_EN
  logic fwd_rs, fwd_rt;
  assign fwd_rs = bus.ex_mem_reg_write && !bus.ex_mem_mem_read && (rs != 5'd0) && (bus.ex_mem_write_reg == rs);
  assign fwd_rt = bus.ex_mem_reg_write && !bus.ex_mem_mem_read && (rt != 5'd0) && (bus.ex_mem_write_reg == rt);
  assign cmp_rs = fwd_rs ? bus.ex_mem_alu_result : rs_data;
  assign cmp_rt = fwd_rt ? bus.ex_mem_alu_result : rt_data;
  assign br_dep_rs = (rs != 5'd0) &&
                     ((id_ex_q.reg_write && bus.ex_write_reg == rs) ||
                      (bus.ex_mem_mem_read && bus.ex_mem_write_reg == rs));
  assign br_dep_rt = (rt != 5'd0) &&
                     ((id_ex_q.reg_write && bus.ex_write_reg == rt) ||
                      (bus.ex_mem_mem_read && bus.ex_mem_write_reg == rt));
`else
  logic unused_alu_result;
  assign unused_alu_result = ^bus.ex_mem_alu_result;
  assign cmp_rs = rs_data;
  assign cmp_rt = rt_data;
  // Without the forward path any pending EX/MEM producer must drain to WB first.
  assign br_dep_rs = (rs != 5'd0) &&
                     ((id_ex_q.reg_write && bus.ex_write_reg == rs) ||
                      ((bus.ex_mem_reg_write || bus.ex_mem_mem_read) && bus.ex_mem_write_reg == rs));
  assign br_dep_rt = (rt != 5'd0) &&
                     ((id_ex_q.reg_write && bus.ex_write_reg == rt) ||
                      ((bus.ex_mem_reg_write || bus.ex_mem_mem_read) && bus.ex_mem_write_reg == rt));
`endif

  assign stall          = load_use || ((is_beq || is_bne) && (br_dep_rs || br_dep_rt));
  assign operands_equal = (cmp_rs == cmp_rt);

  assign bus.stall            = stall;
  assign bus.jump_taken       = is_j && !stall;
  assign bus.branch_eq_taken  = is_beq && operands_equal && !stall;
  assign bus.branch_neq_taken = is_bne && !operands_equal && !stall;
  assign bus.flush_if         = bus.jump_taken || bus.branch_eq_taken || bus.branch_neq_taken;
  assign bus.pc_branch        = bus.if_id_pc_next + {{14{imm16[15]}}, imm16, 2'b00};
  assign bus.pc_jump          = {bus.if_id_pc_next[31:28], bus.if_id_instruction[25:0], 2'b00};

  always_comb begin
    id_ex_d = '0;
    if (!stall) begin
      id_ex_d.reg_write  = dec_reg_write;
      id_ex_d.mem_to_reg = dec_mem_to_reg;
      id_ex_d.mem_read   = dec_mem_read;
      id_ex_d.mem_write  = dec_mem_write;
      id_ex_d.alu_src    = dec_alu_src;
      id_ex_d.reg_dst    = dec_reg_dst;
      id_ex_d.alu_op     = dec_alu_op;
      id_ex_d.rs_data    = rs_data;
      id_ex_d.rt_data    = rt_data;
      id_ex_d.imm        = imm_ext;
      id_ex_d.rs         = rs;
      id_ex_d.rt         = rt;
      id_ex_d.rd         = rd;
      id_ex_d.shamt      = shamt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q  <= '0;
      id_ex_q <= '0;
    end else begin
      regs_q  <= regs_d;
      id_ex_q <= id_ex_d;
    end
  end

  assign bus.id_ex_reg_write  = id_ex_q.reg_write;
  assign bus.id_ex_mem_to_reg = id_ex_q.mem_to_reg;
  assign bus.id_ex_mem_read   = id_ex_q.mem_read;
  assign bus.id_ex_mem_write  = id_ex_q.mem_write;
  assign bus.id_ex_alu_src    = id_ex_q.alu_src;
  assign bus.id_ex_reg_dst    = id_ex_q.reg_dst;
  assign bus.id_ex_alu_op     = id_ex_q.alu_op;
  assign bus.id_ex_rs_data    = id_ex_q.rs_data;
  assign bus.id_ex_rt_data    = id_ex_q.rt_data;
  assign bus.id_ex_imm        = id_ex_q.imm;
  assign bus.id_ex_rs         = id_ex_q.rs;
  assign bus.id_ex_rt         = id_ex_q.rt;
  assign bus.id_ex_rd         = id_ex_q.rd;
  assign bus.id_ex_shamt      = id_ex_q.shamt;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage; the bench plays fetch/EX/MEM/WB by driving the interface.
// Build with or without ID_BRANCH_FWD_EN; the branch-hazard expectations follow the macro.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst;

  id_stage_if bus();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int compareCount  = 0;
  int mismatchCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] pc_next, input logic [31:0] instr);
    bus.if_id_pc_next     = pc_next;
    bus.if_id_instruction = instr;
    #1;
  endtask

  task automatic quietSide();
    bus.wb_reg_write      = 1'b0;
    bus.wb_write_reg      = 5'd0;
    bus.wb_write_data     = 32'd0;
    bus.ex_mem_reg_write  = 1'b0;
    bus.ex_mem_mem_read   = 1'b0;
    bus.ex_mem_write_reg  = 5'd0;
    bus.ex_mem_alu_result = 32'd0;
    bus.ex_write_reg      = 5'd0;
  endtask

  task automatic writeBack(input logic [4:0] r, input logic [31:0] d);
    bus.wb_reg_write  = 1'b1;
    bus.wb_write_reg  = r;
    bus.wb_write_data = d;
  endtask

  // {reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst}
  function automatic logic [31:0] ctrlBits();
    return {26'd0, bus.id_ex_reg_write, bus.id_ex_mem_to_reg, bus.id_ex_mem_read,
            bus.id_ex_mem_write, bus.id_ex_alu_src, bus.id_ex_reg_dst};
  endfunction

  function automatic logic [31:0] redirectBits();
    return {27'd0, bus.stall, bus.flush_if, bus.jump_taken, bus.branch_eq_taken, bus.branch_neq_taken};
  endfunction

  logic [31:0] vecInstr [12] = '{32'h30C5FFFF, 32'h2001FFFF, 32'hAC220004, 32'h3C071234,
                                 32'h000940C3, 32'h016C5022, 32'hFC000000, 32'h00000018,
                                 32'h2862FFFE, 32'h38628000, 32'h00430827, 32'h00020902};
  logic [5:0]  vecCtrl  [12] = '{6'b100010, 6'b100010, 6'b000110, 6'b100010,
                                 6'b100001, 6'b100001, 6'b000000, 6'b000000,
                                 6'b100010, 6'b100010, 6'b100001, 6'b100001};
  logic [3:0]  vecAlu   [12] = '{4'd2, 4'd0, 4'd0, 4'd10, 4'd9, 4'd1, 4'd0, 4'd0,
                                 4'd6, 4'd4, 4'd5, 4'd8};
  logic [31:0] vecImm   [12] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h00000004, 32'h00001234,
                                 32'h000040C3, 32'h00005022, 32'h00000000, 32'h00000018,
                                 32'hFFFFFFFE, 32'h00008000, 32'h00000827, 32'h00000902};

  initial begin
    // Reset for two cycles with a pending WB write to $5 that must be discarded.
    rst = 1'b1;
    quietSide();
    writeBack(5'd5, 32'hAAAA5555);
    applyStimulus(32'd0, 32'd0);
    tick();
    tick();
    checkOutput("rst_ctrl",     ctrlBits(),         32'd0);
    checkOutput("rst_alu_op",   {28'd0, bus.id_ex_alu_op}, 32'd0);
    checkOutput("rst_rs_data",  bus.id_ex_rs_data,  32'd0);
    checkOutput("rst_imm",      bus.id_ex_imm,      32'd0);
    checkOutput("rst_fields",   {12'd0, bus.id_ex_rs, bus.id_ex_rt, bus.id_ex_rd, bus.id_ex_shamt}, 32'd0);
    checkOutput("rst_redirect", redirectBits(),     32'd0);
    checkOutput("rst_pc_jump",  bus.pc_jump,        32'd0);
    checkOutput("rst_pc_branch", bus.pc_branch,     32'd0);
    rst = 1'b0;
    quietSide();

    // add $6,$5,$5: $5 must still be zero.
    applyStimulus(32'h4, 32'h00A53020);
    tick();
    checkOutput("r5_after_rst", bus.id_ex_rs_data, 32'd0);

    // add $4,$3,$3 while WB writes $3 = 0x1234.
    writeBack(5'd3, 32'h00001234);
    applyStimulus(32'h8, 32'h00632020);
    tick();
    quietSide();
    checkOutput("bypass_rs_data", bus.id_ex_rs_data, 32'h00001234);
    checkOutput("bypass_rt_data", bus.id_ex_rt_data, 32'h00001234);
    checkOutput("add_alu_op",     {28'd0, bus.id_ex_alu_op}, 32'd0);
    checkOutput("add_ctrl",       ctrlBits(), 32'b100001);
    checkOutput("add_rd",         {27'd0, bus.id_ex_rd}, 32'd4);
    applyStimulus(32'hC, 32'h00632020);
    tick();
    checkOutput("r3_stored", bus.id_ex_rs_data, 32'h00001234);

    // lw $2,0($1) then add $3,$2,$2: one bubble.
    applyStimulus(32'h10, 32'h8C220000);
    checkOutput("lw_no_stall", redirectBits(), 32'd0);
    tick();
    checkOutput("lw_ctrl", ctrlBits(), 32'b111010);
    checkOutput("lw_rt",   {27'd0, bus.id_ex_rt}, 32'd2);
    applyStimulus(32'h14, 32'h00421820);
    checkOutput("lu_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    checkOutput("lu_bubble_ctrl", ctrlBits(), 32'd0);
    checkOutput("lu_bubble_rs",   {27'd0, bus.id_ex_rs}, 32'd0);
    checkOutput("lu_released",    {31'd0, bus.stall}, 32'd0);
    tick();
    checkOutput("lu_add_ctrl", ctrlBits(), 32'b100001);
    checkOutput("lu_add_rd",   {27'd0, bus.id_ex_rd}, 32'd3);

    // addi $1,$0,5 then beq $1,$1,+4 at PC 0x100.
    applyStimulus(32'h100, 32'h20010005);
    checkOutput("addi_no_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    checkOutput("addi_ctrl", ctrlBits(), 32'b100010);
    checkOutput("addi_imm",  bus.id_ex_imm, 32'd5);
    bus.ex_write_reg = 5'd1;
    applyStimulus(32'h104, 32'h10210004);
    checkOutput("beq_ex_redirect", redirectBits(), 32'b10000);
    checkOutput("beq_pc_branch",   bus.pc_branch, 32'h00000114);
    tick();
    checkOutput("beq_bubble_ctrl", ctrlBits(), 32'd0);
    bus.ex_write_reg      = 5'd0;
    bus.ex_mem_reg_write  = 1'b1;
    bus.ex_mem_write_reg  = 5'd1;
    bus.ex_mem_alu_result = 32'd5;
    #1;
`ifdef ID_BRANCH_FWD_EN
    checkOutput("beq_mem_redirect", redirectBits(), 32'b01010);
    checkOutput("beq_mem_target",   bus.pc_branch, 32'h00000114);
`else
    checkOutput("beq_mem_redirect", redirectBits(), 32'b10000);
    tick();
    quietSide();
    writeBack(5'd1, 32'd5);
    #1;
    checkOutput("beq_wb_redirect", redirectBits(), 32'b01010);
    checkOutput("beq_wb_target",   bus.pc_branch, 32'h00000114);
`endif
    quietSide();
    writeBack(5'd1, 32'd5);
    tick();
    quietSide();

    // bne $1,$0,+4 with $1 = 5 from the register file.
    applyStimulus(32'h118, 32'h14200004);
    checkOutput("bne_redirect",  redirectBits(), 32'b01001);
    checkOutput("bne_pc_branch", bus.pc_branch, 32'h00000128);

    // j 0x40 at PC 0x3000_0000.
    applyStimulus(32'h30000004, 32'h08000040);
    checkOutput("j_redirect", redirectBits(), 32'b01100);
    checkOutput("j_pc_jump",  bus.pc_jump, 32'h30000100);

    // bne $0,$0,8 never taken; beq $0,$0,-1 wraps below zero.
    applyStimulus(32'h200, 32'h14000008);
    checkOutput("bne_zero_redirect", redirectBits(), 32'd0);
    applyStimulus(32'h0, 32'h1000FFFF);
    checkOutput("beq_wrap_redirect", redirectBits(), 32'b01010);
    checkOutput("beq_wrap_target",   bus.pc_branch, 32'hFFFFFFFC);

    // Writes to $0 are neither bypassed nor stored.
    writeBack(5'd0, 32'h0000DEAD);
    applyStimulus(32'h204, 32'h00002020);
    tick();
    quietSide();
    checkOutput("r0_bypass", bus.id_ex_rs_data, 32'd0);
    tick();
    checkOutput("r0_stored", bus.id_ex_rt_data, 32'd0);

    // Decode table: controls, ALU op and immediate extension.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(32'h300 + 32'(i * 4), vecInstr[i]);
      tick();
      checkOutput($sformatf("dec%0d_ctrl", i), ctrlBits(), {26'd0, vecCtrl[i]});
      checkOutput($sformatf("dec%0d_alu", i),  {28'd0, bus.id_ex_alu_op}, {28'd0, vecAlu[i]});
      checkOutput($sformatf("dec%0d_imm", i),  bus.id_ex_imm, vecImm[i]);
    end

    // sra $8,$9,3 field extraction.
    applyStimulus(32'h400, 32'h000940C3);
    tick();
    checkOutput("sra_fields", {12'd0, bus.id_ex_rs, bus.id_ex_rt, bus.id_ex_rd, bus.id_ex_shamt},
                {12'd0, 5'd0, 5'd9, 5'd8, 5'd3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
